pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Sequences reset and lock for the fabric PLL and releases the system reset. It drives the PLL `rst` input and filters the PLL `locked` output. It retries the PLL when lock is not reached or is lost, and holds the system reset until lock has been stable for a set time. It runs on the free-running 50 MHz reference clock that also feeds the PLL, and sits between the board clock/reset and the PLL and fabric reset tree.

## Interface

Parameters:
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before an attempt fails (≥1).
- `LOCK_STABLE`, 1024: consecutive synchronized-lock cycles required before release (≥1).
- `RELEASE_DELAY`, 16: extra cycles `sys_rst` stays high after stable lock (≥1).
- `MAX_RETRIES`, 3: failed attempts allowed after the first before FAULT (0–15).

Ports:
- `refclk`, in, 1: reference clock, 50 MHz, free-running.
- `rst`, in, 1: reset, asynchronous, active-high.
- `locked`, in, 1: PLL lock, asynchronous to `refclk`.
- `pll_rst`, out, 1: drives the PLL `rst`.
- `sys_rst`, out, 1: fabric reset, active-high.
- `ready`, out, 1: high only in RUN.
- `fault`, out, 1: high only in FAULT.
- `retry_cnt`, out, 4: failed attempts since the last success or `rst`.
- `loss_cnt`, out, 8: lock losses seen in RUN; saturates at 255.

## Operation

- `locked` passes through a 2-flop synchronizer (reset to 0) to give `locked_s`. Only `locked_s` is used.
- One shared cycle counter, sized to the largest parameter. It clears on every state change.
- Every output is registered and changes on the edge where the state changes.

States:
- RESET_PLL: `pll_rst`=1, `sys_rst`=1. After `PLL_RST_CYCLES` cycles, go to WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0. If `locked_s`=1, go to STABLE. Otherwise, after `LOCK_TIMEOUT` cycles:
  - if `retry_cnt`==`MAX_RETRIES`, go to FAULT;
  - else increment `retry_cnt` and go to RESET_PLL.
- STABLE: needs `LOCK_STABLE` consecutive cycles with `locked_s`=1, then go to RELEASE. If `locked_s`=0, go back to WAIT_LOCK with a fresh timeout and no retry increment.
- RELEASE: `sys_rst` stays 1. After `RELEASE_DELAY` cycles, go to RUN. If `locked_s`=0, go to WAIT_LOCK as in STABLE.
- RUN: `sys_rst`=0, `ready`=1, `retry_cnt` cleared on entry. If `locked_s`=0:
  - `sys_rst`=1 and `ready`=0 on the next edge;
  - increment `loss_cnt` (saturating);
  - go to RESET_PLL.
- FAULT: `pll_rst`=1, `sys_rst`=1, `fault`=1. The only exit is `rst`.

Reset and edge cases:
- While `rst`=1: state RESET_PLL, `pll_rst`=1, `sys_rst`=1, `ready`=0, `fault`=0, `retry_cnt`=0, `loss_cnt`=0, counter=0, synchronizer=0.
- `rst` asserted mid-operation, including during RUN or FAULT: outputs return to their reset values at once (asynchronously). The sequence restarts from RESET_PLL.
- `locked` stuck at 1 while `pll_rst`=1 is ignored; lock is only evaluated in WAIT_LOCK, STABLE, RELEASE and RUN.

## Timing

- Edge 0 is the first `refclk` rising edge after `rst` deasserts.
- `pll_rst` falls at edge `PLL_RST_CYCLES`.
- With `locked` high throughout: STABLE is entered at edge `PLL_RST_CYCLES`+1. `sys_rst` falls and `ready` rises at edge `PLL_RST_CYCLES`+1+`LOCK_STABLE`+`RELEASE_DELAY`.
- Each failed attempt takes `PLL_RST_CYCLES`+`LOCK_TIMEOUT` cycles. FAULT is entered at edge (`MAX_RETRIES`+1)·(`PLL_RST_CYCLES`+`LOCK_TIMEOUT`).
- Lock-loss reaction in RUN: the `locked` fall shows on `locked_s` after 2 edges, and `sys_rst` rises 1 edge later. Total 3 edges, with `pll_rst`=1 on the same edge.
- A `locked` glitch shorter than one `refclk` period may be missed; this is acceptable.

## Test plan

All scenarios use `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `LOCK_STABLE`=8, `RELEASE_DELAY`=3, `MAX_RETRIES`=2.

- Clean start: `locked`=1 throughout, `rst` released → `pll_rst` falls at edge 4; `sys_rst` falls and `ready` rises at edge 16; `retry_cnt`=0.
- No lock: `locked`=0 throughout → `pll_rst` pulses high at edges 24–27 and 48–51 with `retry_cnt` showing 1 then 2; `fault`=1 at edge 72; `pll_rst` and `sys_rst` stay 1 until `rst`.
- Late lock: `locked` rises on the second attempt → `retry_cnt`=1 until RUN, then 0; `ready` rises 1+8+3 edges after `locked_s` rises in WAIT_LOCK.
- Unstable lock: `locked` drops for 2 cycles midway through STABLE, then stays high → returns to WAIT_LOCK with no retry increment; `ready` rises 12 edges after `locked_s` returns.
- Loss in RUN: drop `locked` → `sys_rst`=1 and `ready`=0 within 3 edges; `loss_cnt` goes 0→1; full restart follows. Repeat 300 times → `loss_cnt`=255.
- Reset mid-sequence: assert `rst` during STABLE and during FAULT → all outputs take reset values with no clock edge needed; after release, the clean-start timing matches the first scenario.

Source files
------------

// File: rtl/pll_lock_supervisor_if.sv
// Control/status bundle of the PLL lock supervisor: PLL lock in, resets and status out.
interface pll_lock_supervisor_if;
    localparam int unsigned RETRY_W = 4;
    localparam int unsigned LOSS_W  = 8;

    logic               locked;
    logic               pll_rst;
    logic               sys_rst;
    logic               ready;
    logic               fault;
    logic [RETRY_W-1:0] retry_cnt;
    logic [LOSS_W-1:0]  loss_cnt;

    // Environment side: drives PLL lock, observes resets and status.
    modport master (
        output locked,
        input  pll_rst, sys_rst, ready, fault, retry_cnt, loss_cnt
    );

    // Supervisor side.
    modport slave (
        input  locked,
        output pll_rst, sys_rst, ready, fault, retry_cnt, loss_cnt
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, filters its lock, retries on
// timeout or loss, and holds the fabric reset until lock has been stable.
module pll_lock_supervisor #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 50000,
    parameter int unsigned LOCK_STABLE    = 1024,
    parameter int unsigned RELEASE_DELAY  = 16,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_lock_supervisor_if.slave  bus
);

    localparam int unsigned RETRY_W = 4;
    localparam int unsigned LOSS_W  = 8;

    // The shared counter must reach the largest per-state cycle count.
    localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CD  = (LOCK_STABLE > RELEASE_DELAY) ? LOCK_STABLE : RELEASE_DELAY;
    localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]   RELEASE_LAST = CNT_W'(RELEASE_DELAY - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
    localparam logic [LOSS_W-1:0]  LOSS_SAT     = {LOSS_W{1'b1}};

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               armed_q;
    logic [1:0]         sync_q;
    logic               locked_s;
    logic               pll_rst_q;
    logic               sys_rst_q;
    logic               ready_q;
    logic               fault_q;
    logic [RETRY_W-1:0] retry_cnt_q;
    logic [LOSS_W-1:0]  loss_cnt_q;

    // Two-flop synchronizer for the asynchronous PLL lock.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.locked};
        end
    end

    assign locked_s = sync_q[1];

    // Sequencer: state, shared cycle counter, retry/loss counters and registered outputs.
    // The first edge after reset only arms it, so the initial PLL reset pulse
    // ends on edge PLL_RST_CYCLES just like a retry pulse lasts PLL_RST_CYCLES edges.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            retry_cnt_q <= '0;
            loss_cnt_q  <= '0;
        end else if (!armed_q) begin
            armed_q <= 1'b1;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            case (state_q)
                S_RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_q   <= S_WAIT_LOCK;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end
                end

                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_q <= S_STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        if (retry_cnt_q == RETRY_LIMIT) begin
                            state_q <= S_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q     <= S_RESET_PLL;
                            retry_cnt_q <= retry_cnt_q + RETRY_W'(1);
                        end
                    end
                end

                // Any drop restarts the lock wait with a fresh timeout, no retry charged.
                S_STABLE: begin
                    if (!locked_s) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q <= S_RELEASE;
                        cnt_q   <= '0;
                    end
                end

                S_RELEASE: begin
                    if (!locked_s) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == RELEASE_LAST) begin
                        state_q     <= S_RUN;
                        cnt_q       <= '0;
                        sys_rst_q   <= 1'b0;
                        ready_q     <= 1'b1;
                        retry_cnt_q <= '0;
                    end
                end

                // Lock loss in service: re-assert both resets and restart the PLL.
                S_RUN: begin
                    cnt_q <= '0;
                    if (!locked_s) begin
                        state_q   <= S_RESET_PLL;
                        pll_rst_q <= 1'b1;
                        sys_rst_q <= 1'b1;
                        ready_q   <= 1'b0;
                        if (loss_cnt_q != LOSS_SAT) begin
                            loss_cnt_q <= loss_cnt_q + LOSS_W'(1);
                        end
                    end
                end

                S_FAULT: begin
                    cnt_q <= '0;
                end

                default: begin
                    state_q   <= S_RESET_PLL;
                    cnt_q     <= '0;
                    pll_rst_q <= 1'b1;
                    sys_rst_q <= 1'b1;
                    ready_q   <= 1'b0;
                    fault_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.sys_rst   = sys_rst_q;
    assign bus.ready     = ready_q;
    assign bus.fault     = fault_q;
    assign bus.retry_cnt = retry_cnt_q;
    assign bus.loss_cnt  = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: randomized lock waveforms checked cycle by
// cycle against an event-timeline model, plus fixed timing points.
module tb_pll_lock_supervisor;

    localparam int P = 4;
    localparam int T = 20;
    localparam int S = 8;
    localparam int D = 3;
    localparam int R = 2;
    localparam int NMAX = 16384;
    localparam logic [15:0] RST_V = {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};

    logic refclk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_total = 0;

    bit          lk    [NMAX + 64];
    logic [15:0] obs   [NMAX];
    logic [15:0] exp_v [NMAX];
    logic [15:0] outs_now;

    pll_lock_supervisor_if bus_if ();

    pll_lock_supervisor #(
        .PLL_RST_CYCLES (P),
        .LOCK_TIMEOUT   (T),
        .LOCK_STABLE    (S),
        .RELEASE_DELAY  (D),
        .MAX_RETRIES    (R)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus_if)
    );

    always #5 refclk = ~refclk;

    assign outs_now = {bus_if.pll_rst, bus_if.sys_rst, bus_if.ready, bus_if.fault,
                       bus_if.retry_cnt, bus_if.loss_cnt};

    // Synchronized lock as the supervisor sees it at edge k (lock value captured two edges earlier).
    function automatic bit ls(input int k);
        if (k < 2 || k - 2 >= NMAX + 64) return 1'b0;
        return lk[k - 2];
    endfunction

    function automatic void put(input int from, input int to, input bit p, input bit s,
                                input bit r, input bit f, input int rc, input int lc);
        for (int k = from; k < to && k < NMAX; k++) exp_v[k] = {p, s, r, f, 4'(rc), 8'(lc)};
    endfunction

    // Timeline model: each attempt is a reset pulse, then a lock search; a search succeeds
    // once lock is seen and then held for S+D more edges, otherwise times out after T edges.
    function automatic void build_model(input int n);
        int a = 0;
        int retry = 0;
        int loss = 0;
        int w, k, j, pre, run_e, t;
        bit fin = 1'b0;
        while (!fin && a < n) begin
            put(a, a + P, 1, 1, 0, 0, retry, loss);
            pre = a + P;
            w = pre;
            run_e = -1;
            t = -1;
            while (run_e < 0 && t < 0 && w < n) begin
                k = w + 1;
                while (k <= w + T && !ls(k)) k++;
                if (k > w + T) begin
                    t = w + T;
                end else begin
                    j = k + 1;
                    while (j <= k + S + D && ls(j)) j++;
                    if (j > k + S + D) run_e = k + S + D;
                    else w = j;
                end
            end
            if (t >= 0) begin
                put(pre, t, 0, 1, 0, 0, retry, loss);
                if (retry == R) begin
                    put(t, n, 1, 1, 0, 1, retry, loss);
                    fin = 1'b1;
                end else begin
                    retry++;
                    a = t;
                end
            end else if (run_e >= 0) begin
                put(pre, run_e, 0, 1, 0, 0, retry, loss);
                retry = 0;
                j = run_e + 1;
                while (j < n && ls(j)) j++;
                put(run_e, j, 0, 0, 1, 0, 0, loss);
                if (loss < 255) loss++;
                a = j;
            end else begin
                put(pre, n, 0, 1, 0, 0, retry, loss);
                fin = 1'b1;
            end
        end
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        bus_if.locked = 1'b0;
        @(negedge refclk);
        @(negedge refclk);
    endtask

    task automatic fill_lk(input bit v);
        for (int k = 0; k < NMAX + 64; k++) lk[k] = v;
    endtask

    // Releases reset at a falling edge and plays lk[], recording outputs after edges 0..n-1.
    task automatic run_trace(input int n);
        bus_if.locked = lk[0];
        rst = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge refclk);
            @(negedge refclk);
            obs[k] = outs_now;
            bus_if.locked = lk[k + 1];
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_total++;
        if (outs_now !== RST_V) $display("FAIL reset_async: got %h want %h", outs_now, RST_V);
        else n_pass++;
        bus_if.locked = 1'b1;
        repeat (3) @(negedge refclk);
        n_total++;
        if (outs_now !== RST_V) $display("FAIL reset_held: got %h want %h", outs_now, RST_V);
        else n_pass++;
    endtask

    task automatic test_clean_start();
        apply_reset();
        fill_lk(1'b1);
        run_trace(40);
        build_model(40);
        for (int k = 0; k < 40; k++) begin
            n_total++;
            if (obs[k] !== exp_v[k]) $display("FAIL clean_trace edge %0d: got %h want %h", k, obs[k], exp_v[k]);
            else n_pass++;
        end
        n_total++;
        if ({obs[3][15], obs[4][15]} !== 2'b10)
            $display("FAIL clean_pll_rst_fall: got %b want 10", {obs[3][15], obs[4][15]});
        else n_pass++;
        n_total++;
        if ({obs[15][14:13], obs[16][14:13]} !== 4'b1001)
            $display("FAIL clean_release_edge16: got %b want 1001", {obs[15][14:13], obs[16][14:13]});
        else n_pass++;
        n_total++;
        if (obs[39][11:8] !== 4'd0) $display("FAIL clean_retry: got %0d want 0", obs[39][11:8]);
        else n_pass++;
    endtask

    task automatic test_no_lock();
        apply_reset();
        fill_lk(1'b0);
        run_trace(90);
        build_model(90);
        for (int k = 0; k < 90; k++) begin
            n_total++;
            if (obs[k] !== exp_v[k]) $display("FAIL nolock_trace edge %0d: got %h want %h", k, obs[k], exp_v[k]);
            else n_pass++;
        end
        n_total++;
        if ({obs[23][15], obs[24][15], obs[27][15], obs[28][15], obs[47][15], obs[48][15], obs[51][15], obs[52][15]} !== 8'b01100110)
            $display("FAIL nolock_pll_pulses: got %b want 01100110",
                     {obs[23][15], obs[24][15], obs[27][15], obs[28][15], obs[47][15], obs[48][15], obs[51][15], obs[52][15]});
        else n_pass++;
        n_total++;
        if ({obs[24][11:8], obs[48][11:8]} !== 8'h12)
            $display("FAIL nolock_retry: got %h want 12", {obs[24][11:8], obs[48][11:8]});
        else n_pass++;
        n_total++;
        if ({obs[71][12], obs[72][12], obs[89][15:12]} !== 6'b011101)
            $display("FAIL nolock_fault: got %b want 011101", {obs[71][12], obs[72][12], obs[89][15:12]});
        else n_pass++;
    endtask

    task automatic test_late_lock();
        for (int it = 0; it < 3; it++) begin
            int r;
            r = int'($urandom_range(44, 27));
            apply_reset();
            for (int k = 0; k < NMAX + 64; k++) lk[k] = (k >= r);
            run_trace(r + 30);
            build_model(r + 30);
            for (int k = 0; k < r + 30; k++) begin
                n_total++;
                if (obs[k] !== exp_v[k]) $display("FAIL late_trace r=%0d edge %0d: got %h want %h", r, k, obs[k], exp_v[k]);
                else n_pass++;
            end
            n_total++;
            if ({obs[r + 12][13], obs[r + 12][11:8], obs[r + 13][13], obs[r + 13][11:8]} !== 10'b0_0001_1_0000)
                $display("FAIL late_ready r=%0d: got %b want 0000110000", r,
                         {obs[r + 12][13], obs[r + 12][11:8], obs[r + 13][13], obs[r + 13][11:8]});
            else n_pass++;
        end
    endtask

    task automatic test_unstable_lock();
        for (int it = 0; it < 3; it++) begin
            int d;
            d = int'($urandom_range(9, 5));
            apply_reset();
            fill_lk(1'b1);
            lk[d] = 1'b0;
            lk[d + 1] = 1'b0;
            run_trace(d + 30);
            build_model(d + 30);
            for (int k = 0; k < d + 30; k++) begin
                n_total++;
                if (obs[k] !== exp_v[k]) $display("FAIL unstable_trace d=%0d edge %0d: got %h want %h", d, k, obs[k], exp_v[k]);
                else n_pass++;
            end
            n_total++;
            if ({obs[16][13], obs[d + 14][13], obs[d + 15][13], obs[d + 15][11:8]} !== 7'b001_0000)
                $display("FAIL unstable_ready d=%0d: got %b want 0010000", d,
                         {obs[16][13], obs[d + 14][13], obs[d + 15][13], obs[d + 15][11:8]});
            else n_pass++;
        end
    endtask

    task automatic test_loss_in_run();
        int idx = 0;
        int z = 0;
        apply_reset();
        fill_lk(1'b1);
        for (int s = 0; s < 300; s++) begin
            int len1, len0;
            len1 = int'($urandom_range(40, 20));
            len0 = int'($urandom_range(2, 1));
            idx += len1;
            if (s == 0) z = idx;
            for (int k = 0; k < len0; k++) lk[idx + k] = 1'b0;
            idx += len0;
        end
        idx += 30;
        run_trace(idx);
        build_model(idx);
        for (int k = 0; k < idx; k++) begin
            n_total++;
            if (obs[k] !== exp_v[k]) $display("FAIL loss_trace edge %0d: got %h want %h", k, obs[k], exp_v[k]);
            else n_pass++;
        end
        n_total++;
        if ({obs[z + 1][15:13], obs[z + 1][7:0], obs[z + 2][15:13], obs[z + 2][7:0]} !== {3'b001, 8'd0, 3'b110, 8'd1})
            $display("FAIL loss_reaction: got %b want 0010000000011000000001",
                     {obs[z + 1][15:13], obs[z + 1][7:0], obs[z + 2][15:13], obs[z + 2][7:0]});
        else n_pass++;
        n_total++;
        if (obs[idx - 1][13:0] !== {1'b1, 1'b0, 4'd0, 8'd255})
            $display("FAIL loss_saturate: got %h want %h", obs[idx - 1][13:0], {1'b1, 1'b0, 4'd0, 8'd255});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        // Reset while in STABLE.
        apply_reset();
        fill_lk(1'b1);
        run_trace(8);
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (outs_now !== RST_V) $display("FAIL mid_stable_reset: got %h want %h", outs_now, RST_V);
        else n_pass++;
        @(negedge refclk);
        @(negedge refclk);
        run_trace(20);
        n_total++;
        if ({obs[3][15], obs[4][15], obs[15][13], obs[16][13]} !== 4'b1001)
            $display("FAIL mid_stable_restart: got %b want 1001", {obs[3][15], obs[4][15], obs[15][13], obs[16][13]});
        else n_pass++;
        // Reset while in FAULT.
        apply_reset();
        fill_lk(1'b0);
        run_trace(80);
        n_total++;
        if (obs[79][15:12] !== 4'b1101) $display("FAIL mid_fault_entry: got %b want 1101", obs[79][15:12]);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (outs_now !== RST_V) $display("FAIL mid_fault_reset: got %h want %h", outs_now, RST_V);
        else n_pass++;
        @(negedge refclk);
        @(negedge refclk);
        fill_lk(1'b1);
        run_trace(20);
        build_model(20);
        for (int k = 0; k < 20; k++) begin
            n_total++;
            if (obs[k] !== exp_v[k]) $display("FAIL mid_fault_restart edge %0d: got %h want %h", k, obs[k], exp_v[k]);
            else n_pass++;
        end
        n_total++;
        if ({obs[3][15], obs[4][15], obs[15][13], obs[16][13]} !== 4'b1001)
            $display("FAIL mid_fault_timing: got %b want 1001", {obs[3][15], obs[4][15], obs[15][13], obs[16][13]});
        else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        bus_if.locked = 1'b0;
        test_reset();
        test_clean_start();
        test_no_lock();
        test_late_lock();
        test_unstable_lock();
        test_loss_in_run();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
